// File: rtl/ofdm_rx_pkg.sv
// ofdm_rx_pkg: shared constants, capture FSM encoding and FIFO entry layout
package ofdm_rx_pkg;
   localparam int N           = 8;
   localparam int CP          = 2;
   localparam int W           = 16;
   localparam int FIFO_DEPTH  = 16;
   localparam int SYNC_STAGES = 2;
   localparam int IDX_W       = $clog2(N);
   localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1;
   localparam int SYM_W       = $clog2(N + CP);
   localparam int BIT_W       = $clog2(W + 2);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } cap_state_t;

   typedef struct packed {
      logic             last;
      logic [IDX_W-1:0] index;
      logic [W-1:0]     data;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);
endpackage

// File: rtl/ofdm_rx_sync_fifo.sv
// ofdm_rx_sync_fifo: synchronous FIFO with registered first-word-fall-through output
// and occupancy level; a write while full is accepted only if a read frees a slot.
module ofdm_rx_sync_fifo #(
   parameter  int DW    = 8,
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data,
   output logic          full,
   input  logic          rd_ready,
   output logic [DW-1:0] rd_data,
   output logic          rd_valid,
   output logic [LW-1:0] level
);
   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
   logic [LW-1:0] lvl_nxt;
   logic          do_wr, do_rd;

   assign full    = level == LW'(DEPTH);
   assign do_rd   = rd_valid && rd_ready;
   assign do_wr   = wr_en && (!full || do_rd);
   assign rd_nxt  = rd_ptr + AW'(do_rd);
   assign lvl_nxt = level + LW'(do_wr) - LW'(do_rd);

   always_ff @(posedge clk)
      if (do_wr) mem[wr_ptr] <= wr_data;

   // Output register tracks the head entry; bypass the write when it lands in an empty FIFO.
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         wr_ptr   <= wr_ptr + AW'(do_wr);
         rd_ptr   <= rd_nxt;
         level    <= lvl_nxt;
         rd_valid <= lvl_nxt != '0;
         rd_data  <= (level == LW'(do_rd)) ? (do_wr ? wr_data : rd_data) : mem[rd_nxt];
      end
endmodule

// File: rtl/ofdm_rx_spi_deframer.sv
// ofdm_rx_spi_deframer: SPI-slave sample deserialiser that strips the cyclic prefix
// and streams the N useful samples of each OFDM symbol with index and last.
module ofdm_rx_spi_deframer
   import ofdm_rx_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             sclk,
   input  logic             cs_n,
   input  logic             mosi,
   input  logic             resync,
   output logic [W-1:0]     rx_data,
   output logic [IDX_W-1:0] rx_index,
   output logic             rx_last,
   output logic             rx_valid,
   input  logic             rx_ready,
   output logic             word_err,
   output logic             ovf,
   output logic [LVL_W-1:0] fifo_level
);
   localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(N + CP - 1);
   localparam logic [SYM_W-1:0] SYM_CP   = SYM_W'(CP);
   localparam logic [BIT_W-1:0] BITS_W   = BIT_W'(W);
   localparam logic [BIT_W-1:0] BITS_SAT = BIT_W'(W + 1);

   logic [SYNC_STAGES-1:0] sclk_s, cs_s, mosi_s;
   logic                   sclk_d, cs_d, sclk_y, cs_y, mosi_y;
   logic                   sclk_rise, cs_fall, cs_rise;
   cap_state_t             state;
   logic [W-1:0]           shreg;
   logic [BIT_W-1:0]       bit_cnt;
   logic [SYM_W-1:0]       sym_cnt, sym_cur;
   logic                   accept, wr_en, full, rd;
   logic [ENTRY_W-1:0]     rd_bits;
   entry_t                 w_entry, r_entry;

   assign sclk_y    = sclk_s[SYNC_STAGES-1];
   assign cs_y      = cs_s[SYNC_STAGES-1];
   assign mosi_y    = mosi_s[SYNC_STAGES-1];
   assign sclk_rise = sclk_y && !sclk_d;
   assign cs_fall   = !cs_y && cs_d;
   assign cs_rise   = cs_y && !cs_d;

   // Synchronisers idle at the released-bus levels so reset never fakes an edge.
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         sclk_s <= '0;
         cs_s   <= '1;
         mosi_s <= '0;
         sclk_d <= 1'b0;
         cs_d   <= 1'b1;
      end else begin
         sclk_s <= SYNC_STAGES'({sclk_s, sclk});
         cs_s   <= SYNC_STAGES'({cs_s, cs_n});
         mosi_s <= SYNC_STAGES'({mosi_s, mosi});
         sclk_d <= sclk_y;
         cs_d   <= cs_y;
      end

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state    <= IDLE;
         shreg    <= '0;
         bit_cnt  <= '0;
         word_err <= 1'b0;
      end else begin
         word_err <= 1'b0;
         case (state)
            IDLE: if (cs_fall) begin
               state   <= SHIFT;
               bit_cnt <= '0;
            end
            SHIFT: begin
               if (sclk_rise) begin
                  shreg   <= {shreg[W-2:0], mosi_y};
                  bit_cnt <= (bit_cnt == BITS_SAT) ? bit_cnt : bit_cnt + 1'b1;
               end
               if (cs_rise) state <= DONE;
            end
            DONE: begin
               state    <= IDLE;
               word_err <= bit_cnt != BITS_W;
            end
            default: state <= IDLE;
         endcase
      end

   // resync zeroes the slot seen by a coinciding accept, so that word lands in CP slot 0.
   assign accept  = (state == DONE) && (bit_cnt == BITS_W);
   assign sym_cur = resync ? '0 : sym_cnt;
   assign wr_en   = accept && (sym_cur >= SYM_CP);
   assign rd      = rx_valid && rx_ready;
   assign w_entry = '{last: sym_cur == SYM_LAST, index: IDX_W'(sym_cur - SYM_CP), data: shreg};

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         sym_cnt <= '0;
         ovf     <= 1'b0;
      end else begin
         sym_cnt <= accept ? ((sym_cur == SYM_LAST) ? '0 : sym_cur + 1'b1) : sym_cur;
         if (wr_en && full && !rd) ovf <= 1'b1;
      end

   ofdm_rx_sync_fifo #(.DW(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en),
      .wr_data  (w_entry),
      .full     (full),
      .rd_ready (rx_ready),
      .rd_data  (rd_bits),
      .rd_valid (rx_valid),
      .level    (fifo_level)
   );

   assign r_entry  = rd_bits;
   assign rx_data  = r_entry.data;
   assign rx_index = r_entry.index;
   assign rx_last  = r_entry.last;
endmodule
